imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the program-load path into the cpu instruction memory.
//   Accepts a stream of 16-bit instruction words over a valid/ready handshake and
//   writes them to consecutive addresses from 0 using im_write/im_addr/im_wdata.
//   Holds the cpu in reset for the whole load, then releases it so the program runs.
// PARAMETERS
//   ADDR_W    6    instruction-memory address width; matches the 6-bit pc
//   DATA_W    16   instruction word width
//   PROG_LEN  64   words per load; legal range 1..2**ADDR_W
// PORTS
//   clk         in   1       system clock; all state changes on the rising edge
//   rst         in   1       asynchronous reset, active-low
//   start       in   1       one-cycle pulse that begins a load
//   word_valid  in   1       source has a word on word_data
//   word_data   in   DATA_W  instruction word from the source
//   word_ready  out  1       loader accepts word_data this cycle
//   im_write    out  1       instruction-memory write enable, one cycle per word
//   im_addr     out  ADDR_W  instruction-memory write address
//   im_wdata    out  DATA_W  instruction-memory write data
//   cpu_rst     out  1       active-high reset to the cpu core
//   busy        out  1       high while a load is in progress (LOAD or RELEASE)
//   done        out  1       high while the cpu runs a fully loaded program
//   word_count  out  ADDR_W+1 number of words accepted in the current load
// BEHAVIOUR
//   - Reset (rst=0, asynchronous): state=IDLE, cpu_rst=1, word_ready=0,
//     im_write=0, im_addr=0, im_wdata=0, busy=0, done=0, word_count=0.
//   - FSM states: IDLE -> LOAD -> RELEASE -> RUN.
//     IDLE: cpu_rst=1. start=1 moves to LOAD next cycle and clears word_count.
//     LOAD: word_ready=1 (a registered state decode, so no combinational path
//       from word_valid). A handshake is a cycle with word_valid && word_ready.
//       Handshake k (k from 0) at cycle N gives im_write=1 at N+1 with
//       im_addr=k and im_wdata equal to the word captured at N. word_count
//       increments at N+1. No handshake means im_write=0 on the next cycle,
//       and addresses stay contiguous across gaps.
//     The handshake for word PROG_LEN-1 moves the FSM to RELEASE. word_ready
//       is 0 from the next cycle, so no word beyond PROG_LEN is accepted.
//     RELEASE (1 cycle): carries the im_write for the last word, with cpu_rst
//       still 1.
//     RUN: cpu_rst=0, done=1, busy=0, word_ready=0. im_addr/im_wdata hold their
//       last values and im_write=0.
//   - Latency: the last handshake at cycle N gives the last im_write at N+1 and
//     cpu_rst=0, done=1 at N+2.
//   - start is ignored in LOAD and RELEASE.
//   - start in RUN: cpu_rst=1 and done=0 on the next cycle, state=LOAD,
//     word_count=0, and the next write goes to address 0.
//   - Address never wraps. With PROG_LEN=2**ADDR_W the last write goes to
//     address 2**ADDR_W-1, and word_count reaches 2**ADDR_W, which is why it is
//     ADDR_W+1 bits wide.
//   - im_write is never high in IDLE or RUN. It is high for exactly PROG_LEN
//     cycles per load.
//   - rst during LOAD or RELEASE: immediate return to the reset values. The cpu
//     stays in reset, and a partially written memory is left as is. A new start
//     reloads from address 0.
// TESTING
//   1. Apply rst=0 mid-cycle -> all outputs at reset values immediately,
//      cpu_rst=1, state IDLE. Release rst -> outputs unchanged until start.
//   2. PROG_LEN=4, start, then words A001..A004 with word_valid held high ->
//      im_write on 4 consecutive cycles with addr 0..3 and matching data,
//      cpu_rst=0 and done=1 two cycles after the 4th handshake, word_count=4.
//   3. PROG_LEN=4, word_valid low on alternate cycles -> im_write only after
//      handshakes, addr 0,1,2,3 contiguous, data order preserved.
//   4. Default PROG_LEN=64 with continuous stream, then word_valid held high
//      after the last word -> 64 writes, last at addr 63, no write to addr 0
//      afterwards, word_count=64, word_ready=0.
//   5. start pulsed during LOAD -> no effect. start pulsed in RUN -> cpu_rst=1
//      next cycle, word_count=0, next write at addr 0, done returns after reload.
//   6. rst=0 after 2 handshakes -> im_write=0, cpu_rst=1, word_count=0
//      immediately. Release rst, start -> first write at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: writer side of the program-load path into the cpu instruction memory.
// Accepts PROG_LEN instruction words over a valid/ready handshake and writes them to
// consecutive addresses from 0. The cpu is held in reset for the whole load. After the
// last write, the cpu is released to run the program.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   start       one-cycle pulse that begins a load (honoured in IDLE and RUN only)
//   word_valid  source presents a word on word_data
//   word_data   instruction word from the source
//   word_ready  loader accepts word_data this cycle (registered state decode)
//   im_write    instruction-memory write enable, one cycle per accepted word
//   im_addr     instruction-memory write address
//   im_wdata    instruction-memory write data
//   cpu_rst     active-high reset to the cpu core
//   busy        load in progress (LOAD or RELEASE)
//   done        cpu is running a fully loaded program
//   word_count  words accepted in the current load (one bit wider than the address)
module imem_loader #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PROG_LEN = 64  // legal range 1..2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              word_ready,
  output logic              im_write,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned    LastWord = PROG_LEN - 1;
  localparam logic [ADDR_W:0] LastIdx = LastWord[ADDR_W:0];

  typedef enum logic [1:0] {StIdle, StLoad, StRelease, StRun} state_e;

  state_e state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      word_ready <= 1'b0;
      im_write   <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      im_write <= 1'b0;
      unique case (state_q)
        StIdle, StRun: begin
          if (start) begin
            state_q    <= StLoad;
            word_count <= '0;
            word_ready <= 1'b1;
            cpu_rst    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        StLoad: begin
          if (word_valid && word_ready) begin
            // word_count before the increment is the address of this word, so
            // addresses stay contiguous however the source paces its words.
            im_write   <= 1'b1;
            im_addr    <= word_count[ADDR_W-1:0];
            im_wdata   <= word_data;
            word_count <= word_count + 1'b1;
            if (word_count == LastIdx) begin
              state_q    <= StRelease;
              word_ready <= 1'b0;
            end
          end
        end
        StRelease: begin
          // This cycle carries the write of the last word; release the cpu after it.
          state_q <= StRun;
          cpu_rst <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0, valid4 = 1'b0;
  logic [15:0] data4 = '0;
  logic        start64 = 1'b0, valid64 = 1'b0;
  logic [15:0] data64 = '0;

  logic        ready4, write4, crst4, busy4, done4;
  logic [5:0]  addr4;
  logic [15:0] wdata4;
  logic [6:0]  cnt4;

  logic        ready64, write64, crst64, busy64, done64;
  logic [5:0]  addr64;
  logic [15:0] wdata64;
  logic [6:0]  cnt64;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(6), .DATA_W(16), .PROG_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .word_valid(valid4), .word_data(data4),
    .word_ready(ready4), .im_write(write4), .im_addr(addr4), .im_wdata(wdata4),
    .cpu_rst(crst4), .busy(busy4), .done(done4), .word_count(cnt4)
  );

  imem_loader #(.ADDR_W(6), .DATA_W(16), .PROG_LEN(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .word_valid(valid64), .word_data(data64),
    .word_ready(ready64), .im_write(write64), .im_addr(addr64), .im_wdata(wdata64),
    .cpu_rst(crst64), .busy(busy64), .done(done64), .word_count(cnt64)
  );

  typedef struct {
    logic        st;
    logic        vl;
    logic [15:0] dat;
    logic        rdy;
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] wd;
    logic        crst;
    logic        bsy;
    logic        dn;
    logic [6:0]  cnt;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic st, logic vl, logic [15:0] dat, logic rdy, logic wr,
                              logic [5:0] addr, logic [15:0] wd, logic crst, logic bsy,
                              logic dn, logic [6:0] cnt);
    vec_t v;
    v.st = st; v.vl = vl; v.dat = dat; v.rdy = rdy; v.wr = wr; v.addr = addr;
    v.wd = wd; v.crst = crst; v.bsy = bsy; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input vec_t v);
    chk({tag, ".word_ready"}, 32'(ready4), 32'(v.rdy));
    chk({tag, ".im_write"},   32'(write4), 32'(v.wr));
    chk({tag, ".im_addr"},    32'(addr4),  32'(v.addr));
    chk({tag, ".im_wdata"},   32'(wdata4), 32'(v.wd));
    chk({tag, ".cpu_rst"},    32'(crst4),  32'(v.crst));
    chk({tag, ".busy"},       32'(busy4),  32'(v.bsy));
    chk({tag, ".done"},       32'(done4),  32'(v.dn));
    chk({tag, ".word_count"}, 32'(cnt4),   32'(v.cnt));
  endtask

  initial begin
    vec_t rv;
    rv = mk(0, 0, 16'h0, 0, 0, 6'd0, 16'h0, 1, 0, 0, 7'd0);  // reset values

    // Outputs only: inputs in the record are don't-care for these checks.
    // Table: each record's inputs are driven in the same cycle its outputs are checked.
    // Outputs are registered, so a record's inputs show up in the next record.
    vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 6'd0, 16'h0000, 1, 0, 0, 7'd0);
    vecs[1]  = mk(0, 1, 16'hA001, 1, 0, 6'd0, 16'h0000, 1, 1, 0, 7'd0);
    vecs[2]  = mk(0, 1, 16'hA002, 1, 1, 6'd0, 16'hA001, 1, 1, 0, 7'd1);
    vecs[3]  = mk(0, 1, 16'hA003, 1, 1, 6'd1, 16'hA002, 1, 1, 0, 7'd2);
    vecs[4]  = mk(0, 1, 16'hA004, 1, 1, 6'd2, 16'hA003, 1, 1, 0, 7'd3);
    vecs[5]  = mk(0, 1, 16'hBEEF, 0, 1, 6'd3, 16'hA004, 1, 1, 0, 7'd4);
    vecs[6]  = mk(0, 1, 16'hBEEF, 0, 0, 6'd3, 16'hA004, 0, 0, 1, 7'd4);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 6'd3, 16'hA004, 0, 0, 1, 7'd4);
    // Reload from RUN with word_valid low on alternate cycles.
    vecs[8]  = mk(1, 0, 16'h0000, 0, 0, 6'd3, 16'hA004, 0, 0, 1, 7'd4);
    vecs[9]  = mk(0, 0, 16'h0000, 1, 0, 6'd3, 16'hA004, 1, 1, 0, 7'd0);
    vecs[10] = mk(0, 1, 16'hB001, 1, 0, 6'd3, 16'hA004, 1, 1, 0, 7'd0);
    vecs[11] = mk(0, 0, 16'h0000, 1, 1, 6'd0, 16'hB001, 1, 1, 0, 7'd1);
    vecs[12] = mk(0, 1, 16'hB002, 1, 0, 6'd0, 16'hB001, 1, 1, 0, 7'd1);
    vecs[13] = mk(0, 0, 16'h0000, 1, 1, 6'd1, 16'hB002, 1, 1, 0, 7'd2);
    vecs[14] = mk(0, 1, 16'hB003, 1, 0, 6'd1, 16'hB002, 1, 1, 0, 7'd2);
    vecs[15] = mk(0, 0, 16'h0000, 1, 1, 6'd2, 16'hB003, 1, 1, 0, 7'd3);
    vecs[16] = mk(0, 1, 16'hB004, 1, 0, 6'd2, 16'hB003, 1, 1, 0, 7'd3);
    vecs[17] = mk(0, 0, 16'h0000, 0, 1, 6'd3, 16'hB004, 1, 1, 0, 7'd4);
    vecs[18] = mk(0, 0, 16'h0000, 0, 0, 6'd3, 16'hB004, 0, 0, 1, 7'd4);
    // Reload, with start pulsed in LOAD and in RELEASE (both ignored).
    vecs[19] = mk(1, 0, 16'h0000, 0, 0, 6'd3, 16'hB004, 0, 0, 1, 7'd4);
    vecs[20] = mk(0, 1, 16'hC001, 1, 0, 6'd3, 16'hB004, 1, 1, 0, 7'd0);
    vecs[21] = mk(1, 0, 16'h0000, 1, 1, 6'd0, 16'hC001, 1, 1, 0, 7'd1);
    vecs[22] = mk(0, 1, 16'hC002, 1, 0, 6'd0, 16'hC001, 1, 1, 0, 7'd1);
    vecs[23] = mk(0, 1, 16'hC003, 1, 1, 6'd1, 16'hC002, 1, 1, 0, 7'd2);
    vecs[24] = mk(0, 1, 16'hC004, 1, 1, 6'd2, 16'hC003, 1, 1, 0, 7'd3);
    vecs[25] = mk(1, 1, 16'hDEAD, 0, 1, 6'd3, 16'hC004, 1, 1, 0, 7'd4);
    vecs[26] = mk(0, 0, 16'h0000, 0, 0, 6'd3, 16'hC004, 0, 0, 1, 7'd4);
    vecs[27] = mk(0, 0, 16'h0000, 0, 0, 6'd3, 16'hC004, 0, 0, 1, 7'd4);

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk4("async_reset", rv);
    chk("async_reset.dut64.cpu_rst", 32'(crst64), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk4("after_reset_idle", rv);
    end

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      start4 = vecs[i].st;
      valid4 = vecs[i].vl;
      data4  = vecs[i].dat;
      chk4($sformatf("vec%0d", i), vecs[i]);
    end
    start4 = 1'b0;
    valid4 = 1'b0;

    // Full-length load on the PROG_LEN=64 instance, valid held high past the end.
    @(negedge clk);
    start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    valid64 = 1'b1;
    data64  = 16'h5000;
    chk("full.first_ready", 32'(ready64), 32'd1);
    chk("full.first_count", 32'(cnt64), 32'd0);
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      data64 = 16'(16'h5000 + j);
      chk($sformatf("full%0d.im_write", j), 32'(write64), 32'd1);
      chk($sformatf("full%0d.im_addr", j), 32'(addr64), 32'(j - 1));
      chk($sformatf("full%0d.im_wdata", j), 32'(wdata64), 32'(16'h5000 + j - 1));
      chk($sformatf("full%0d.word_count", j), 32'(cnt64), 32'(j));
      chk($sformatf("full%0d.word_ready", j), 32'(ready64), (j < 64) ? 32'd1 : 32'd0);
      chk($sformatf("full%0d.cpu_rst", j), 32'(crst64), 32'd1);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("full_run.im_write", 32'(write64), 32'd0);
      chk("full_run.im_addr", 32'(addr64), 32'd63);
      chk("full_run.word_count", 32'(cnt64), 32'd64);
      chk("full_run.word_ready", 32'(ready64), 32'd0);
      chk("full_run.cpu_rst", 32'(crst64), 32'd0);
      chk("full_run.done", 32'(done64), 32'd1);
      chk("full_run.busy", 32'(busy64), 32'd0);
    end
    valid64 = 1'b0;

    // Reset in the middle of a load, then reload from address 0.
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    valid4 = 1'b1;
    data4  = 16'hD001;
    @(negedge clk);
    data4 = 16'hD002;
    chk("midrst.write0_addr", 32'(addr4), 32'd0);
    @(negedge clk);
    valid4 = 1'b0;
    chk("midrst.count_before", 32'(cnt4), 32'd2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk4("midrst.reset", rv);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk4("midrst.idle", rv);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    valid4 = 1'b1;
    data4  = 16'hE001;
    @(negedge clk);
    valid4 = 1'b0;
    chk("reload.im_write", 32'(write4), 32'd1);
    chk("reload.im_addr", 32'(addr4), 32'd0);
    chk("reload.im_wdata", 32'(wdata4), 32'hE001);
    chk("reload.word_count", 32'(cnt4), 32'd1);
    chk("reload.cpu_rst", 32'(crst4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
